t07_fpu_fxp_mult_seq: RTL and testbench



---
 rtl/t07_fpu_fxp_mult_seq.sv | 163 ++++++++++++++++
 tb/tb_t07_fpu_fxp_mult_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/t07_fpu_fxp_mult_seq.sv
// Sequential shift-add multiplier for sign-magnitude fixed-point operands.
// One adder, WIDTH iterations, with a normalised, saturating, optionally rounded result.
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   inA, inB         operand magnitudes (WIDTH bits, FRAC fractional bits)
//   signA, signB     operand signs
//   busy             operation in flight (RUN or DONE)
//   done             one-cycle pulse; result/sign/overflow valid from here
//   result           product magnitude, held until the next done
//   sign             product sign, held (never a negative zero)
//   overflow         magnitude saturated, held
module t07_fpu_fxp_mult_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 23,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             signA,
    input  logic             signB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sign,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_cnt;
    logic               r_s;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_sign;
    logic               r_ovf;

    logic               w_zero_op;
    logic [WIDTH:0]     w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_p_nxt;
    logic [CW-1:0]      w_cnt_inc;
    logic [WIDTH-1:0]   w_m;
    logic [WIDTH-FRAC-1:0] w_hi;
    logic               w_rbit;
    logic [WIDTH:0]     w_mr;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_sgn;

    // Iteration: add A into the upper half when B[0] is set, then
    // shift {carry, P} right by one.
    assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                     + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_carry   = w_sum[WIDTH];
    assign w_p_nxt   = {w_carry, w_sum[WIDTH-1:0], r_p[WIDTH-1:1]};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_zero_op = (inA == '0) || (inB == '0);

    // Normalisation: drop FRAC low bits; anything above the window overflows.
    assign w_m  = r_p[FRAC+WIDTH-1:FRAC];
    assign w_hi = r_p[2*WIDTH-1:FRAC+WIDTH];

    generate
        if (ROUND != 0 && FRAC > 0) begin : g_round
            assign w_rbit = r_p[FRAC-1];
        end else begin : g_trunc
            assign w_rbit = 1'b0;
        end
    endgenerate

    assign w_mr  = {1'b0, w_m} + {{WIDTH{1'b0}}, w_rbit};
    assign w_ovf = (|w_hi) | w_mr[WIDTH];
    assign w_res = w_ovf ? '1 : w_mr[WIDTH-1:0];
    // A zero magnitude always reports a positive sign.
    assign w_sgn = r_s & (|w_res);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_op ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_cnt_inc == CW'(WIDTH)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_s      <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_a   <= inA;
                r_b   <= inB;
                r_s   <= signA ^ signB;
                r_p   <= '0;
                r_cnt <= '0;
            end
            if (r_state == S_RUN) begin
                r_p   <= w_p_nxt;
                r_b   <= r_b >> 1;
                r_cnt <= w_cnt_inc;
            end
            if (r_state == S_DONE) begin
                r_result <= w_res;
                r_sign   <= w_sgn;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign sign     = r_sign;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_t07_fpu_fxp_mult_seq.sv
// Bench for t07_fpu_fxp_mult_seq: WIDTH=32, FRAC=23, truncating and rounding
// instances driven in parallel, expected results queued at issue time.
module tb_t07_fpu_fxp_mult_seq;

    localparam int W = 32;
    localparam int F = 23;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic [W-1:0] inA, inB;
    logic         signA, signB;

    logic         busy0, done0, sign0, ovf0;
    logic [W-1:0] res0;
    logic         busy1, done1, sign1, ovf1;
    logic [W-1:0] res1;

    typedef struct {
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic         s0;
        logic         s1;
        logic         o0;
        logic         o1;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t_first, t_second, n_dn;

    t07_fpu_fxp_mult_seq #(.WIDTH(W), .FRAC(F), .ROUND(0)) u_trunc (
        .clk(clk), .nrst(nrst), .start(start),
        .inA(inA), .inB(inB), .signA(signA), .signB(signB),
        .busy(busy0), .done(done0), .result(res0),
        .sign(sign0), .overflow(ovf0)
    );

    t07_fpu_fxp_mult_seq #(.WIDTH(W), .FRAC(F), .ROUND(1)) u_round (
        .clk(clk), .nrst(nrst), .start(start),
        .inA(inA), .inB(inB), .signA(signA), .signB(signB),
        .busy(busy1), .done(done1), .result(res1),
        .sign(sign1), .overflow(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sa, input logic sb_);
        exp_t         e;
        logic [63:0]  p;
        logic [31:0]  m;
        logic [32:0]  mr;
        logic         hi;
        p    = {32'b0, a} * {32'b0, b};
        m    = p[54:23];
        hi   = |p[63:55];
        mr   = {1'b0, m} + {32'b0, p[22]};
        e.o0 = hi;
        e.r0 = e.o0 ? 32'hFFFF_FFFF : m;
        e.o1 = hi | mr[32];
        e.r1 = e.o1 ? 32'hFFFF_FFFF : mr[31:0];
        e.s0 = (sa ^ sb_) && (e.r0 != 0);
        e.s1 = (sa ^ sb_) && (e.r1 != 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (E0).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sa, input logic sb_);
        sb.push_back(model(a, b, sa, sb_));
        inA   = a;
        inB   = b;
        signA = sa;
        signB = sb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        inA   = $urandom;
        inB   = $urandom;
        signA = 1'($urandom);
        signB = 1'($urandom);
    endtask

    task automatic wait_done(input int lat, input string tag);
        int   n;
        bit   got;
        exp_t e;
        n   = 0;
        got = 0;
        while (n < 200 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done0) got = 1;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        if (got) begin
            if (sb.size() == 0) begin
                check({tag, "_sbempty"}, 64'(0), 64'(1));
            end else begin
                e = sb.pop_front();
                check({tag, "_res"},  64'(res0), 64'(e.r0));
                check({tag, "_sign"}, 64'(sign0), 64'(e.s0));
                check({tag, "_ovf"},  64'(ovf0), 64'(e.o0));
                check({tag, "_resR"}, 64'(res1), 64'(e.r1));
                check({tag, "_signR"}, 64'(sign1), 64'(e.s1));
                check({tag, "_ovfR"}, 64'(ovf1), 64'(e.o1));
                check({tag, "_doneR"}, 64'(done1), 64'(1));
                check({tag, "_busy"}, 64'(busy0), 64'(0));
            end
        end
    endtask

    initial begin
        nrst  = 1'b0;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        signA = 1'b0;
        signB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_done", 64'(done0), 64'(0));
        check("rst_res", 64'(res0), 64'(0));
        check("rst_sign", 64'(sign0), 64'(0));
        check("rst_ovf", 64'(ovf0), 64'(0));
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Unity
        issue(32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0);
        check("unity_busy", 64'(busy0), 64'(1));
        wait_done(33, "unity");
        @(posedge clk);
        #1;
        check("unity_pulse", 64'(done0), 64'(0));

        // Mixed sign, then back-to-back from the done cycle
        issue(32'h00C0_0000, 32'h0100_0000, 1'b0, 1'b1);
        wait_done(33, "mixed");
        t_first = cyc;
        issue(32'h0040_0000, 32'h0040_0000, 1'b0, 1'b0);
        wait_done(33, "b2b");
        t_second = cyc;
        check("b2b_gap", 64'(t_second - t_first), 64'(34));

        // Saturation, held afterwards
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
        wait_done(33, "sat");
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold_res", 64'(res0), 64'hFFFF_FFFF);
        check("sat_hold_ovf", 64'(ovf0), 64'(1));

        // Rounding: truncates to zero (positive), rounds up to one
        issue(32'h0000_0001, 32'h0040_0000, 1'b1, 1'b0);
        wait_done(33, "round");

        // Zero fast path
        issue(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0);
        wait_done(1, "zero");

        // Start while busy is ignored
        issue(32'h00C0_0000, 32'h00C0_0000, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        inA   = 32'h0;
        inB   = 32'h5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(28, "ignore");
        n_dn = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done0) n_dn++;
        end
        check("ignore_noq", 64'(n_dn), 64'(0));

        // Reset mid-operation
        issue(32'h0080_0000, 32'h00C0_0000, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("mrst_busy", 64'(busy0), 64'(0));
        check("mrst_done", 64'(done0), 64'(0));
        check("mrst_res", 64'(res0), 64'(0));
        check("mrst_sign", 64'(sign0), 64'(0));
        check("mrst_ovf", 64'(ovf0), 64'(0));
        n_dn = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done0) n_dn++;
        end
        check("mrst_nodone", 64'(n_dn), 64'(0));
        nrst = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h0080_0000, 32'h00C0_0000, 1'b1, 1'b0);
        wait_done(33, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
